// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared constants for the sequential restoring divider: operand widths,
//   iteration counter width and the FSM state encodings.
//   No ports (package).
package seq_divider_pkg;

  localparam int DVD_W = 16;
  localparam int DVS_W = 9;
  localparam int CNT_W = $clog2(DVD_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Request/result bundle of the sequential divider.
//   Ports (signals):
//     start      request, sampled only in IDLE or DONE
//     dividend   unsigned dividend, latched when start is accepted
//     divisor    unsigned divisor, latched when start is accepted
//     busy       high while iterating
//     done       one-cycle pulse, results valid
//     quotient   registered quotient
//     remainder  registered remainder
//     div0       divide-by-zero flag, held with the results
//   Modports: master (requester), slave (divider).
interface seq_divider_if;

  logic                              start;
  logic [seq_divider_pkg::DVD_W-1:0] dividend;
  logic [seq_divider_pkg::DVS_W-1:0] divisor;
  logic                              busy;
  logic                              done;
  logic [seq_divider_pkg::DVD_W-1:0] quotient;
  logic [seq_divider_pkg::DVS_W-1:0] remainder;
  logic                              div0;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div0
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div0
  );

endinterface

// File: rtl/seq_divider_subtractor_nbit.sv
// subtractor_nbit
//   Combinational in1 - in2 of width W with a borrow output.
//   Ports:
//     in1     minuend
//     in2     subtrahend
//     diff    low W bits of in1 - in2
//     borrow  1 when in2 > in1
module subtractor_nbit #(
  parameter int W = 10
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // One extra bit on the subtract; its MSB is the borrow.
  always_comb begin
    {borrow, diff} = {1'b0, in1} - {1'b0, in2};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential restoring divider producing one quotient bit per clock.
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous active-high reset
//     bus   seq_divider_if.slave: start/dividend/divisor in,
//           busy/done/quotient/remainder/div0 out
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DVS_W-1:0] r_q, r_d;
  logic [DVD_W-1:0] q_q, q_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;

  logic [DVS_W:0]   r_shift;
  logic [DVS_W:0]   diff;
  logic             borrow;

  // Partial remainder shifted left, taking in the next dividend bit.
  assign r_shift = {r_q, q_q[DVD_W-1]};

  subtractor_nbit #(
    .W (DVS_W + 1)
  ) u_sub (
    .in1    (r_shift),
    .in2    ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide by zero finishes immediately without iterating.
            state_d = ST_DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
            div0_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
            count_d = '0;
            r_d     = '0;
            q_d     = bus.dividend;
            dvs_d   = bus.divisor;
            div0_d  = 1'b0;
          end
        end
      end

      ST_CALC: begin
        // Restore on borrow; a successful subtract fits DVS_W bits since
        // the difference is below the divisor.
        r_d     = borrow ? r_shift[DVS_W-1:0] : diff[DVS_W-1:0];
        q_d     = {q_q[DVD_W-2:0], ~borrow};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DVD_W - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = r_d;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider: directed cases plus a random sweep
//   against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int DVD_W = 16;
  localparam int DVS_W = 9;
  localparam int MAX_WAIT = 60;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic refDiv(input int a, input int b, output int q, output int r,
                        output int z);
    if (b == 0) begin
      q = (1 << DVD_W) - 1;
      r = 0;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endtask

  // Present one request; returns after the accepting edge (edge 0).
  task automatic applyStimulus(input int a, input int b, input bit holdStart);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = DVD_W'(a);
    bus.divisor  = DVS_W'(b);
    @(posedge clk);
    #1;
    if (!holdStart) bus.start = 1'b0;
  endtask

  // Count cycles after edge 0 until done; mode 1 injects a second request
  // and a dividend change while the first one is iterating.
  task automatic waitDone(input int mode, output int doneCyc, output int busyCnt);
    doneCyc = 0;
    busyCnt = 0;
    for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
      @(negedge clk);
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        doneCyc = cyc;
        break;
      end
      if (mode == 1) begin
        if (cyc == 3) begin
          bus.start    = 1'b1;
          bus.dividend = 16'd50;
          bus.divisor  = 9'd2;
        end
        if (cyc == 4) bus.start = 1'b0;
        if (cyc == 5) bus.dividend = 16'd999;
      end
    end
  endtask

  task automatic runCase(input string tag, input int a, input int b, input int mode);
    int doneCyc, busyCnt, eq, er, ez;
    refDiv(a, b, eq, er, ez);
    applyStimulus(a, b, 1'b0);
    waitDone(mode, doneCyc, busyCnt);
    checkOutput({tag, "_doneCycle"}, doneCyc, (b == 0) ? 1 : DVD_W + 1);
    checkOutput({tag, "_busyCycles"}, busyCnt, (b == 0) ? 0 : DVD_W);
    checkOutput({tag, "_quotient"}, bus.quotient, eq);
    checkOutput({tag, "_remainder"}, bus.remainder, er);
    checkOutput({tag, "_div0"}, bus.div0, ez);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, bus.done, 0);
  endtask

  initial begin
    int doneCyc, busyCnt, firstDone, secondDone, eq, er, ez;
    int a, b;
    assertCount  = 0;
    failCount    = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_quotient", bus.quotient, 0);
    checkOutput("reset_remainder", bus.remainder, 0);
    checkOutput("reset_div0", bus.div0, 0);

    runCase("t1_1000_7", 1000, 7, 0);
    checkOutput("t1_quotient_const", bus.quotient, 142);
    checkOutput("t1_remainder_const", bus.remainder, 6);
    runCase("t2_65535_511", 65535, 511, 0);
    runCase("t2_5_9", 5, 9, 0);
    runCase("t2_0_1", 0, 1, 0);
    runCase("t3_1234_0", 1234, 0, 0);
    runCase("t3_10_3", 10, 3, 0);
    runCase("t4_100_9_ignore", 100, 9, 1);

    // Reset in the middle of an operation aborts it.
    applyStimulus(1000, 7, 1'b0);
    for (int cyc = 1; cyc < 8; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_busy", bus.busy, 0);
    checkOutput("t5_done", bus.done, 0);
    checkOutput("t5_quotient", bus.quotient, 0);
    checkOutput("t5_remainder", bus.remainder, 0);
    checkOutput("t5_div0", bus.div0, 0);
    waitDone(0, doneCyc, busyCnt);
    checkOutput("t5_noDone", doneCyc, 0);
    runCase("t5_fresh", 1000, 7, 0);

    // Back-to-back with start held high through DONE.
    applyStimulus(300, 17, 1'b1);
    firstDone  = 0;
    secondDone = 0;
    for (int cyc = 1; cyc <= 2 * MAX_WAIT; cyc++) begin
      @(negedge clk);
      if (bus.done && firstDone == 0) begin
        firstDone = cyc;
        checkOutput("t6_first_quotient", bus.quotient, 17);
        checkOutput("t6_first_remainder", bus.remainder, 11);
        bus.dividend = 16'd40000;
        bus.divisor  = 9'd400;
      end else if (bus.done) begin
        secondDone = cyc;
        checkOutput("t6_second_quotient", bus.quotient, 100);
        checkOutput("t6_second_remainder", bus.remainder, 0);
        bus.start = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    checkOutput("t6_firstDoneCycle", firstDone, DVD_W + 1);
    checkOutput("t6_doneSpacing", secondDone - firstDone, DVD_W + 1);
    repeat (3) @(negedge clk);

    // Random sweep against the reference model and the invariant.
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 511));
      refDiv(a, b, eq, er, ez);
      applyStimulus(a, b, 1'b0);
      waitDone(0, doneCyc, busyCnt);
      checkOutput($sformatf("rand%0d_doneCycle", i), doneCyc, (b == 0) ? 1 : DVD_W + 1);
      checkOutput($sformatf("rand%0d_quotient", i), bus.quotient, eq);
      checkOutput($sformatf("rand%0d_remainder", i), bus.remainder, er);
      checkOutput($sformatf("rand%0d_div0", i), bus.div0, ez);
      if (b != 0) begin
        checkOutput($sformatf("rand%0d_invariant", i),
                    int'(bus.quotient) * b + int'(bus.remainder), a);
        checkOutput($sformatf("rand%0d_remBelowDivisor", i),
                    (int'(bus.remainder) < b) ? 1 : 0, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
